// File: rtl/opamp_trim_sar_ctrl_if.sv
// Signal bundle between the opamp trim sequencer and its surroundings.
// The controller side uses the slave modport; the driver side uses master.
//
// Request semantics: start is a single-cycle request. It is accepted only on
// an edge where the sequencer is idle (busy == 0 and done == 0). While busy is
// high, the sequencer is not ready and start is dropped rather than queued.
// done is a one-cycle completion pulse with no acknowledge. abort and wr_en
// are level-sampled strobes that act only in the states where they apply.
interface opamp_trim_sar_ctrl_if #(
  parameter int TRIM_W = 6
);
  logic              start;
  logic              abort;
  logic              cmp_in;
  logic              wr_en;
  logic              wr_sel;
  logic [TRIM_W-1:0] wr_data;
  logic [1:0]        cal_en;
  logic [TRIM_W-1:0] trim0;
  logic [TRIM_W-1:0] trim1;
  logic              busy;
  logic              done;
  logic [1:0]        sat;
  logic [1:0]        state_dbg;

  modport master (
    output start, abort, cmp_in, wr_en, wr_sel, wr_data,
    input  cal_en, trim0, trim1, busy, done, sat, state_dbg
  );

  modport slave (
    input  start, abort, cmp_in, wr_en, wr_sel, wr_data,
    output cal_en, trim0, trim1, busy, done, sat, state_dbg
  );
endinterface

// File: rtl/opamp_trim_sar_ctrl.sv
// Offset-trim sequencer for two opamps sharing one bias.
// On start, channel 0 and then channel 1 are trimmed by successive
// approximation. The result for each channel is the largest code at which the
// synchronised comparator reads 0. Outside calibration, the trims hold and can
// be written manually.
// Legal parameters: TRIM_W 2..8, SETTLE_CYC >= 3, 2**CNT_W >= SETTLE_CYC.
module opamp_trim_sar_ctrl #(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 64,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  rst,
  opamp_trim_sar_ctrl_if.slave bus
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [TRIM_W-1:0] MIDSCALE   = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(TRIM_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAL0 = 2'd1,
    S_CAL1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [TRIM_W-1:0] trim0_q;
  logic [TRIM_W-1:0] trim1_q;
  logic [TRIM_W-1:0] shadow0_q;
  logic [TRIM_W-1:0] shadow1_q;
  logic [1:0]        cal_en_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        sat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  bit_idx_q;

  // Two-flop synchroniser for the pad comparator
  logic cmp_meta_q;
  logic cmp_s;

  // Decision-path values for the channel currently being trimmed
  logic [TRIM_W-1:0] cur_code;
  logic [TRIM_W-1:0] dec_code;
  logic [TRIM_W-1:0] step_code;
  logic [IDX_W-1:0]  idx_dn;
  logic              last_bit;
  logic              dec_sat;

  // Bring the asynchronous comparator into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_meta_q <= 1'b0;
      cmp_s      <= 1'b0;
    end else begin
      cmp_meta_q <= bus.cmp_in;
      cmp_s      <= cmp_meta_q;
    end
  end

  // Resolve the bit under test and prepare the next trial code
  always_comb begin
    cur_code  = (state_q == S_CAL1) ? trim1_q : trim0_q;
    dec_code  = cur_code;
    // Comparator high means the trial code is past the trip point
    if (cmp_s) dec_code[bit_idx_q] = 1'b0;
    idx_dn    = bit_idx_q - IDX_ONE;
    last_bit  = (bit_idx_q == '0);
    step_code = dec_code;
    if (!last_bit) step_code[idx_dn] = 1'b1;
    dec_sat   = (dec_code == '0) || (dec_code == '1);
  end

  // Sequencer: state, trims, shadows, settle timer and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      trim0_q   <= MIDSCALE;
      trim1_q   <= MIDSCALE;
      shadow0_q <= MIDSCALE;
      shadow1_q <= MIDSCALE;
      cal_en_q  <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 2'b00;
      cnt_q     <= '0;
      bit_idx_q <= IDX_TOP;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // A same-cycle write is dropped so the shadows hold pre-write values
            state_q   <= S_CAL0;
            busy_q    <= 1'b1;
            cal_en_q  <= 2'b01;
            sat_q     <= 2'b00;
            shadow0_q <= trim0_q;
            shadow1_q <= trim1_q;
            trim0_q   <= MIDSCALE;
            bit_idx_q <= IDX_TOP;
            cnt_q     <= CNT_RELOAD;
          end else if (bus.wr_en) begin
            if (bus.wr_sel) trim1_q <= bus.wr_data;
            else            trim0_q <= bus.wr_data;
          end
        end

        S_CAL0, S_CAL1: begin
          if (bus.abort) begin
            // Abort beats a coincident decision; only the live channel is restored
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cal_en_q  <= 2'b00;
            cnt_q     <= '0;
            bit_idx_q <= IDX_TOP;
            if (state_q == S_CAL0) trim0_q <= shadow0_q;
            else                   trim1_q <= shadow1_q;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!last_bit) begin
            if (state_q == S_CAL0) trim0_q <= step_code;
            else                   trim1_q <= step_code;
            bit_idx_q <= idx_dn;
            cnt_q     <= CNT_RELOAD;
          end else if (state_q == S_CAL0) begin
            // Channel 0 finished: hand over to channel 1
            trim0_q   <= dec_code;
            sat_q[0]  <= dec_sat;
            state_q   <= S_CAL1;
            cal_en_q  <= 2'b10;
            trim1_q   <= MIDSCALE;
            bit_idx_q <= IDX_TOP;
            cnt_q     <= CNT_RELOAD;
          end else begin
            // Channel 1 finished: whole calibration complete
            trim1_q   <= dec_code;
            sat_q[1]  <= dec_sat;
            state_q   <= S_DONE;
            cal_en_q  <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            bit_idx_q <= IDX_TOP;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          cal_en_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.cal_en    = cal_en_q;
  assign bus.trim0     = trim0_q;
  assign bus.trim1     = trim1_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sat       = sat_q;
  assign bus.state_dbg = state_q;

endmodule
